// File: rtl/byte_serial_add_seq_pkg.sv
// byte_serial_add_seq_pkg: shared FSM encoding and slice width for the byte-serial adder
package byte_serial_add_seq_pkg;
    localparam int BYTE_W = 8;
    typedef logic [1:0] state_t;
    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_RUN  = 2'd1;
    localparam state_t S_DONE = 2'd2;
endpackage

// File: rtl/byte_serial_add_seq_rca.sv
// byte_serial_add_seq_rca: 8-bit ripple-carry adder slice (rippleCarry8Bit)
//   a, b : byte operands      cin  : carry in
//   s    : byte sum           cout : carry out of bit 7
module rippleCarry8Bit
    import byte_serial_add_seq_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] s,
    output logic              cout
);
    logic [BYTE_W:0] c;
    assign c[0] = cin;
    for (genvar i = 0; i < BYTE_W; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign cout = c[BYTE_W];
endmodule

// File: rtl/byte_serial_add_seq.sv
// byte_serial_add_seq: W-bit add done one byte per cycle on a single shared 8-bit slice
//   clk, rst (async, active-high)
//   in_valid/in_ready   : operand handshake for a, b, c_in
//   out_valid/out_ready : result handshake for sum, c_out, ovf
module byte_serial_add_seq
    import byte_serial_add_seq_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BYTE_W*NBYTES-1:0] a,
    input  logic [BYTE_W*NBYTES-1:0] b,
    input  logic                     c_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BYTE_W*NBYTES-1:0] sum,
    output logic                     c_out,
    output logic                     ovf
);
    localparam int W     = BYTE_W * NBYTES;
    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int LAST  = NBYTES - 1;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [W-1:0]       a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic               c_out_q, c_out_d, ovf_q, ovf_d;
    logic [BYTE_W-1:0]  slice_a, slice_b, slice_sum;
    logic               slice_co, last;

    assign slice_a = a_q[BYTE_W*idx_q +: BYTE_W];
    assign slice_b = b_q[BYTE_W*idx_q +: BYTE_W];
    assign last    = idx_q == IDX_W'(LAST);

    rippleCarry8Bit u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .s    (slice_sum),
        .cout (slice_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = in_valid ? S_RUN : S_IDLE;
            S_RUN:   state_d = last ? S_DONE : S_RUN;
            S_DONE:  state_d = out_ready ? S_IDLE : S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = state_q == S_IDLE;
        out_valid = state_q == S_DONE;
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        if (in_ready && in_valid) begin
            a_d     = a;
            b_d     = b;
            carry_d = c_in;
            idx_d   = '0;
            sum_d   = '0;
        end else if (state_q == S_RUN) begin
            sum_d[BYTE_W*idx_q +: BYTE_W] = slice_sum;
            carry_d = slice_co;
            if (last) begin
                c_out_d = slice_co;
                // a^b^s at the MSB recovers the carry into bit W-1
                ovf_d   = a_q[W-1] ^ b_q[W-1] ^ slice_sum[BYTE_W-1] ^ slice_co;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    assign sum   = sum_q;
    assign c_out = c_out_q;
    assign ovf   = ovf_q;
endmodule

// File: tb/tb_byte_serial_add_seq.sv
// tb_byte_serial_add_seq: randomized self-checking bench against an arithmetic reference model
module tb_byte_serial_add_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        c_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] sum;
    logic        c_out;
    logic        ovf;
    int          n_chk = 0;
    int          n_pass = 0;

    byte_serial_add_seq #(.NBYTES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [31:0] oa, input logic [31:0] ob, input logic oc,
                          input int stall, input bit inject, input bit rnd_rdy);
        logic [32:0] full;
        logic        exp_ovf;
        logic [31:0] held;
        int          lat;
        int          w;
        full    = {1'b0, oa} + {1'b0, ob} + {32'd0, oc};
        exp_ovf = (oa[31] == ob[31]) && (full[31] != oa[31]);
        w = 0;
        while (!in_ready && w < 20) begin
            tick();
            w++;
        end
        check("in_ready_wait", 64'(in_ready), 64'd1);
        a = oa;
        b = ob;
        c_in = oc;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            in_valid  = inject && lat < 3;
            a         = $urandom;
            b         = $urandom;
            c_in      = 1'($urandom);
            out_ready = rnd_rdy ? 1'($urandom) : 1'b0;
            tick();
            lat++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("latency", 64'(lat), 64'd4);
        check("sum", 64'(sum), 64'(full[31:0]));
        check("c_out", 64'(c_out), 64'(full[32]));
        check("ovf", 64'(ovf), 64'(exp_ovf));
        held = sum;
        for (int i = 0; i < stall; i++) begin
            in_valid = inject;
            tick();
            check("stall_hold", {29'd0, out_valid, in_ready, c_out, sum},
                  {29'd0, 1'b1, 1'b0, full[32], held});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("release", {62'd0, out_valid, in_ready}, {62'd0, 1'b0, 1'b1});
    endtask

    initial begin
        bit seen;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_flags", {62'd0, c_out, ovf}, 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        tick();
        tick();
        rst = 1'b0;
        tick();

        run_op(32'h000000FF, 32'h00000001, 1'b0, 0, 1'b0, 1'b0);
        run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 0, 1'b0, 1'b0);
        run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 0, 1'b0, 1'b0);
        run_op(32'h00000000, 32'h00000000, 1'b1, 0, 1'b1, 1'b0);
        run_op(32'h80000000, 32'h80000000, 1'b1, 5, 1'b1, 1'b0);

        a = 32'hDEADBEEF;
        b = 32'h01234567;
        c_in = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_outs", {30'd0, out_valid, c_out, sum}, 64'd0);
        check("async_rst_state", {62'd0, in_ready, ovf}, {62'd0, 1'b1, 1'b0});
        tick();
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen |= out_valid;
        end
        check("no_partial_valid", 64'(seen), 64'd0);
        run_op(32'h12345678, 32'h11111111, 1'b0, 0, 1'b0, 1'b0);

        for (int k = 0; k < 100; k++)
            run_op($urandom, $urandom, 1'($urandom), int'($urandom_range(0, 3)),
                   1'($urandom), 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
